// File: rtl/i2c_eeprom_pkg.sv
// Shared types and constants for the I2C EEPROM slave controller.
package i2c_eeprom_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_WORD_ADDR,
    ST_WORD_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } state_e;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h50;
  localparam int         COL_W            = 3;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes raw SCL/SDA, detects SCL edges and START/STOP conditions.
module i2c_line_sync
  import i2c_eeprom_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_prev_q;
  logic       sda_prev_q;
  logic       scl_s;

  // Reset to the idle bus level so leaving reset produces no false edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl_s      = scl_sync_q[1];
  assign sda_o      = sda_sync_q[1];
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_o;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_o;

endmodule

// File: rtl/i2c_eeprom_slave_ctrl.sv
// 24Cxx-style I2C slave engine driving a paged EEPROM array.
// Optional WRITE_PROTECT_EN adds a wp input that NACKs and suppresses data writes.
module i2c_eeprom_slave_ctrl
  import i2c_eeprom_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
  parameter int         PAGE_NUM = 32,
  parameter int         ROW_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_i,
  input  logic             sda_i,
`ifdef WRITE_PROTECT_EN
  input  logic             wp,
`endif
  output logic             sda_oe,
  output logic             mem_write,
  output logic [ROW_W-1:0] mem_row,
  output logic [COL_W-1:0] mem_col,
  output logic [7:0]       mem_wdata,
  input  logic [7:0]       mem_rdata,
  output state_e           dbg_state_o
);

  localparam int                ADDR_W    = ROW_W + COL_W;
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(PAGE_NUM * 8 - 1);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det, wp_s;

  i2c_line_sync u_line_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

`ifdef WRITE_PROTECT_EN
  logic [1:0] wp_sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wp_sync_q <= 2'b00;
    else        wp_sync_q <= {wp_sync_q[0], wp};
  end
  assign wp_s = wp_sync_q[1];
`else
  assign wp_s = 1'b0;
`endif

  state_e             state_q;
  logic [2:0]         bit_cnt_q;
  logic [6:0]         shift_q;
  logic               rw_q;
  logic               sda_oe_q;
  logic               wr_pend_q, wr_blk_q, inc_pend_q, mem_write_q;
  logic [ROW_W-1:0]   row_q;
  logic [COL_W-1:0]   col_q;
  logic [7:0]         wdata_q;
  logic [7:0]         rx_byte;
  logic [ADDR_W-1:0]  ptr, ptr_next;

  assign rx_byte  = {shift_q, sda_s};
  assign ptr      = {row_q, col_q};
  assign ptr_next = (ptr == ADDR_LAST) ? '0 : ptr + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      wr_pend_q   <= 1'b0;
      wr_blk_q    <= 1'b0;
      inc_pend_q  <= 1'b0;
      mem_write_q <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      wdata_q     <= '0;
    end else begin
      // Write pipeline runs independently of bus events, so a late STOP cannot cancel it.
      wr_pend_q   <= 1'b0;
      mem_write_q <= wr_pend_q & ~wr_blk_q;
      inc_pend_q  <= wr_pend_q;
      if (inc_pend_q) col_q <= col_q + COL_W'(1);

      if (start_det) begin
        state_q   <= ST_DEV_ADDR;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
      end else if (stop_det) begin
        state_q   <= ST_IDLE;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
      end else begin
        unique case (state_q)
          ST_DEV_ADDR, ST_WORD_ADDR, ST_WR_DATA: begin
            if (scl_rise) begin
              shift_q   <= rx_byte[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (state_q == ST_DEV_ADDR) begin
                  rw_q    <= rx_byte[0];
                  state_q <= (rx_byte[7:1] == DEV_ADDR) ? ST_DEV_ACK : ST_WAIT_STOP;
                end else if (state_q == ST_WORD_ADDR) begin
                  {row_q, col_q} <= rx_byte[ADDR_W-1:0];
                  state_q        <= ST_WORD_ACK;
                end else begin
                  wdata_q   <= rx_byte;
                  wr_pend_q <= 1'b1;
                  wr_blk_q  <= wp_s;
                  state_q   <= ST_WR_ACK;
                end
              end
            end
          end
          // bit_cnt_q doubles as the ACK phase: 0 = waiting to drive, 1 = driving.
          ST_DEV_ACK, ST_WORD_ACK, ST_WR_ACK: begin
            if (scl_fall) begin
              if (bit_cnt_q == 3'd0) begin
                sda_oe_q  <= (state_q == ST_WR_ACK) ? ~wr_blk_q : 1'b1;
                bit_cnt_q <= 3'd1;
              end else begin
                bit_cnt_q <= '0;
                if (state_q == ST_DEV_ACK && rw_q) begin
                  shift_q        <= mem_rdata[6:0];
                  sda_oe_q       <= ~mem_rdata[7];
                  {row_q, col_q} <= ptr_next;
                  state_q        <= ST_RD_DATA;
                end else begin
                  sda_oe_q <= 1'b0;
                  state_q  <= (state_q == ST_DEV_ACK) ? ST_WORD_ADDR : ST_WR_DATA;
                end
              end
            end
          end
          ST_RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt_q == 3'd7) begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= '0;
                state_q   <= ST_RD_ACK;
              end else begin
                sda_oe_q  <= ~shift_q[6];
                shift_q   <= {shift_q[5:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              if (sda_s) state_q   <= ST_WAIT_STOP;
              else       bit_cnt_q <= 3'd1;
            end else if (scl_fall && bit_cnt_q == 3'd1) begin
              shift_q        <= mem_rdata[6:0];
              sda_oe_q       <= ~mem_rdata[7];
              {row_q, col_q} <= ptr_next;
              bit_cnt_q      <= '0;
              state_q        <= ST_RD_DATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe      = sda_oe_q;
  assign mem_write   = mem_write_q;
  assign mem_row     = row_q;
  assign mem_col     = col_q;
  assign mem_wdata   = wdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i2c_eeprom_slave_ctrl.sv
// Bench for i2c_eeprom_slave_ctrl: bit-level I2C master, address-echo array, write scoreboard.
module tb_i2c_eeprom_slave_ctrl;
  import i2c_eeprom_pkg::*;

  localparam int Q = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_m, sda_m, wp_r;
  logic       sda_line;
  logic       sda_oe, mem_write;
  logic [4:0] mem_row;
  logic [2:0] mem_col;
  logic [7:0] mem_wdata, mem_rdata;
  state_e     dbg_state;

  int checks = 0;
  int errors = 0;
  int n_writes = 0;
  int n_exp = 0;
  int oe_cnt = 0;
  int ptr = 0;
  logic        wr_prev = 1'b0;
  logic [15:0] exp_q[$];
  logic [7:0]  tx_q[$];

  always #5 clk = ~clk;

  assign sda_line  = sda_m & ~sda_oe;
  assign mem_rdata = {mem_row, mem_col};

  i2c_eeprom_slave_ctrl #(.DEV_ADDR(7'h50), .PAGE_NUM(32), .ROW_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scl_i       (scl_m),
    .sda_i       (sda_line),
`ifdef WRITE_PROTECT_EN
    .wp          (wp_r),
`endif
    .sda_oe      (sda_oe),
    .mem_write   (mem_write),
    .mem_row     (mem_row),
    .mem_col     (mem_col),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .dbg_state_o (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write pulse must match the next expected {addr, data}.
  always @(negedge clk) begin
    if (rst_n && mem_write) begin
      logic [15:0] e;
      n_writes++;
      check("wr_pulse_width", 32'(wr_prev), 32'd0);
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 32'(mem_write), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'({mem_row, mem_col}), 32'(e[15:8]));
        check("wr_data", 32'(mem_wdata), 32'(e[7:0]));
      end
    end
    if (sda_oe) oe_cnt++;
    wr_prev = mem_write;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(2 * Q);
    sda_m = 1'b0; wait_clk(2 * Q);
    scl_m = 1'b0;
  endtask

  task automatic m_stop();
    wait_clk(Q); sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(2 * Q);
    sda_m = 1'b1; wait_clk(2 * Q);
  endtask

  task automatic send_bit(input logic b);
    wait_clk(Q); sda_m = b; wait_clk(Q);
    scl_m = 1'b1; wait_clk(2 * Q);
    scl_m = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    wait_clk(Q); sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    b = sda_line; wait_clk(Q);
    scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    send_bit(nack);
  endtask

  // Model: write bytes land at ptr and the column wraps inside the page.
  task automatic write_txn(input logic [7:0] waddr);
    logic ack;
    logic [7:0] d;
    m_start();
    send_byte(8'hA0, ack); check("wr_dev_ack", 32'(ack), 32'd1);
    send_byte(waddr, ack); check("wr_word_ack", 32'(ack), 32'd1);
    ptr = int'(waddr);
    while (tx_q.size() > 0) begin
      d = tx_q.pop_front();
      exp_q.push_back({8'(ptr), d});
      n_exp++;
      send_byte(d, ack); check("wr_data_ack", 32'(ack), 32'd1);
      ptr = (ptr & 'hF8) | ((ptr + 1) & 7);
    end
    m_stop();
  endtask

  // Model: the array echoes its address, so byte k of a read equals ptr+k mod 256.
  task automatic read_txn(input bit set_addr, input logic [7:0] waddr, input int n);
    logic ack;
    logic [7:0] d;
    m_start();
    if (set_addr) begin
      send_byte(8'hA0, ack); check("rd_dev_w_ack", 32'(ack), 32'd1);
      send_byte(waddr, ack); check("rd_word_ack", 32'(ack), 32'd1);
      ptr = int'(waddr);
      m_start();
    end
    send_byte(8'hA1, ack); check("rd_dev_r_ack", 32'(ack), 32'd1);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, d);
      check("rd_data", 32'(d), 32'(ptr));
      ptr = (ptr + 1) % 256;
    end
    m_stop();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack;
    int   w0, o0;
    scl_m = 1'b1; sda_m = 1'b1; wp_r = 1'b0; rst_n = 1'b0;
    wait_clk(5);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_addr", 32'({mem_row, mem_col}), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    wait_clk(5);

    // Directed write: 0x13 -> row 2 col 3, then col 4.
    w0 = n_writes;
    tx_q = '{8'h5A, 8'hC3};
    write_txn(8'h13);
    wait_clk(4);
    check("wr_count_basic", 32'(n_writes - w0), 32'd2);

    // Page wrap: 0x0E gives cols 6,7,0,1 in row 1.
    for (int i = 0; i < 4; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    write_txn(8'h0E);
    wait_clk(4);
    check("wr_count_wrap", 32'(n_writes - w0), 32'd6);
    check("wrap_ptr_col", 32'(mem_col), 32'd2);

    // Random read with repeated START, no writes allowed.
    w0 = n_writes;
    read_txn(1'b1, 8'h1F, 3);
    check("rd_no_write", 32'(n_writes - w0), 32'd0);

    // Address mismatch: never drives SDA.
    o0 = oe_cnt;
    m_start();
    send_byte(8'hA2, ack); check("mm_dev_nack", 32'(ack), 32'd0);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'($urandom_range(0, 255)), ack);
      check("mm_byte_nack", 32'(ack), 32'd0);
    end
    m_stop();
    check("mm_sda_oe_quiet", 32'(oe_cnt - o0), 32'd0);
    check("mm_no_write", 32'(n_writes - w0), 32'd0);

    // Read wrap at the top address.
    read_txn(1'b1, 8'hFF, 2);

    // Randomized writes and reads, including current-address reads.
    for (int it = 0; it < 4; it++) begin
      int nb;
      nb = $urandom_range(1, 10);
      for (int i = 0; i < nb; i++) tx_q.push_back(8'($urandom_range(0, 255)));
      write_txn(8'($urandom_range(0, 255)));
      read_txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), $urandom_range(1, 4));
    end

    // Reset in the middle of a read while the slave is pulling SDA low.
    m_start();
    send_byte(8'hA0, ack); check("rr_dev_ack", 32'(ack), 32'd1);
    send_byte(8'h00, ack); check("rr_word_ack", 32'(ack), 32'd1);
    m_start();
    send_byte(8'hA1, ack); check("rr_dev_r_ack", 32'(ack), 32'd1);
    wait_clk(Q);
    check("rr_driving", 32'(sda_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rr_sda_oe", 32'(sda_oe), 32'd0);
    check("rr_mem_write", 32'(mem_write), 32'd0);
    check("rr_addr", 32'({mem_row, mem_col}), 32'd0);
    check("rr_wdata", 32'(mem_wdata), 32'd0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(3);
    check("rr_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    scl_m = 1'b1; sda_m = 1'b1;
    wait_clk(8);
    ptr = 0;
    read_txn(1'b0, 8'h00, 2);

`ifdef WRITE_PROTECT_EN
    wp_r = 1'b1;
    wait_clk(4);
    w0 = n_writes;
    m_start();
    send_byte(8'hA0, ack); check("wp_dev_ack", 32'(ack), 32'd1);
    send_byte(8'h00, ack); check("wp_word_ack", 32'(ack), 32'd1);
    send_byte(8'h11, ack); check("wp_data_nack", 32'(ack), 32'd0);
    m_stop();
    check("wp_no_write", 32'(n_writes - w0), 32'd0);
    wp_r = 1'b0;
    ptr = 1;
    read_txn(1'b0, 8'h00, 1);
`endif

    wait_clk(10);
    check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    check("sb_write_total", 32'(n_writes), 32'(n_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
